// File: rtl/ball_motion_ctrl.sv
// Per-frame ball scheduler for the pong display: moves the ball once per vsync,
// bounces it off the wall, the screen edges and the player bar, and runs serve/miss.
module ball_motion_ctrl #(
    parameter int BALL_SIZE   = 8,
    parameter int STEP        = 2,
    parameter int WALL_X      = 175,
    parameter int BAR_X       = 580,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int SERVE_X     = 320,
    parameter int SERVE_Y     = 236,
    parameter int MISS_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync,
    input  logic       serve,
    input  logic [9:0] bar_top,
    input  logic [9:0] bar_bot,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       ball_vis,
    output logic [1:0] state,
    output logic       hit,
    output logic       frame_upd,
    output logic [7:0] miss_cnt
);

    localparam int HOLD_W = $clog2(MISS_FRAMES + 1);

    localparam logic signed [10:0] C_SIZE = 11'(BALL_SIZE);
    localparam logic signed [10:0] C_STEP = 11'(STEP);
    localparam logic signed [10:0] C_WALL = 11'(WALL_X);
    localparam logic signed [10:0] C_BAR  = 11'(BAR_X);
    localparam logic signed [10:0] C_W    = 11'(SCREEN_W);
    localparam logic signed [10:0] C_H    = 11'(SCREEN_H);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        MISS = 2'b10,
        BAD  = 2'b11
    } state_t;

    state_t              state_q, state_n;
    logic                dx_q, dx_n;   // 1 = moving right
    logic                dy_q, dy_n;   // 1 = moving down
    logic [HOLD_W-1:0]   hold_q, hold_n;
    logic                vsync_d;
    logic                tick;

    logic [9:0]          x_n, y_n;
    logic                vis_n, hit_n, upd_n;
    logic [7:0]          miss_n;

    logic signed [10:0]  x_s, y_s, top_s, bot_s;
    logic signed [10:0]  nx, ny;
    logic                ndx, ndy, bar_bounce, off_screen;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign tick  = vsync & ~vsync_d;
    assign state = state_q;

    always_comb begin
        x_s   = $signed({1'b0, ball_x});
        y_s   = $signed({1'b0, ball_y});
        top_s = $signed({1'b0, bar_top});
        bot_s = $signed({1'b0, bar_bot});

        ny  = dy_q ? (y_s + C_STEP) : (y_s - C_STEP);
        ndy = dy_q;
        if (dy_q && (ny + C_SIZE >= C_H)) begin
            ny  = C_H - C_SIZE;
            ndy = 1'b0;
        end else if (!dy_q && (y_s < C_STEP)) begin
            ny  = '0;
            ndy = 1'b1;
        end

        // Horizontal resolution uses the post-vertical ny for the bar overlap test.
        nx         = dx_q ? (x_s + C_STEP) : (x_s - C_STEP);
        ndx        = dx_q;
        bar_bounce = 1'b0;
        off_screen = 1'b0;
        if (!dx_q && (nx <= C_WALL)) begin
            nx  = C_WALL;
            ndx = 1'b1;
        end else if (dx_q && (nx + C_SIZE >= C_BAR) && (x_s + C_SIZE <= C_BAR) &&
                     (ny + C_SIZE > top_s) && (ny < bot_s)) begin
            nx         = C_BAR - C_SIZE;
            ndx        = 1'b0;
            bar_bounce = 1'b1;
        end else if (dx_q && (nx + C_SIZE >= C_W)) begin
            off_screen = 1'b1;
        end

        state_n = state_q;
        x_n     = ball_x;
        y_n     = ball_y;
        dx_n    = dx_q;
        dy_n    = dy_q;
        vis_n   = ball_vis;
        hit_n   = 1'b0;
        upd_n   = 1'b0;
        miss_n  = miss_cnt;
        hold_n  = hold_q;

        case (state_q)
            IDLE: begin
                vis_n = 1'b1;
                if (serve) state_n = RUN;
            end
            RUN: begin
                if (tick) begin
                    if (off_screen) begin
                        state_n = MISS;
                        vis_n   = 1'b0;
                        miss_n  = sat_inc(miss_cnt);
                        hold_n  = HOLD_W'(MISS_FRAMES);
                    end else begin
                        x_n   = nx[9:0];
                        y_n   = ny[9:0];
                        dx_n  = ndx;
                        dy_n  = ndy;
                        hit_n = bar_bounce;
                        upd_n = 1'b1;
                    end
                end
            end
            MISS: begin
                if (tick) begin
                    if (hold_q <= HOLD_W'(1)) begin
                        state_n = IDLE;
                        x_n     = 10'(SERVE_X);
                        y_n     = 10'(SERVE_Y);
                        dx_n    = 1'b1;
                        dy_n    = 1'b1;
                        vis_n   = 1'b1;
                        hold_n  = '0;
                    end else begin
                        hold_n = hold_q - HOLD_W'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                x_n     = 10'(SERVE_X);
                y_n     = 10'(SERVE_Y);
                dx_n    = 1'b1;
                dy_n    = 1'b1;
                vis_n   = 1'b1;
                hold_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ball_x    <= 10'(SERVE_X);
            ball_y    <= 10'(SERVE_Y);
            dx_q      <= 1'b1;
            dy_q      <= 1'b1;
            ball_vis  <= 1'b1;
            hit       <= 1'b0;
            frame_upd <= 1'b0;
            miss_cnt  <= '0;
            hold_q    <= '0;
            vsync_d   <= 1'b1;
        end else begin
            state_q   <= state_n;
            ball_x    <= x_n;
            ball_y    <= y_n;
            dx_q      <= dx_n;
            dy_q      <= dy_n;
            ball_vis  <= vis_n;
            hit       <= hit_n;
            frame_upd <= upd_n;
            miss_cnt  <= miss_n;
            hold_q    <= hold_n;
            vsync_d   <= vsync;
        end
    end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Bench for ball_motion_ctrl: directed serve/bounce/miss/reset scenarios plus
// randomized play, all compared against a frame-level integer model of the game.
module tb_ball_motion_ctrl;

    localparam int BALL_SIZE   = 8;
    localparam int STEP        = 2;
    localparam int WALL_X      = 175;
    localparam int BAR_X       = 580;
    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
    localparam int SERVE_X     = 320;
    localparam int SERVE_Y     = 236;
    localparam int MISS_FRAMES = 60;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       vsync = 1'b1;
    logic       serve = 1'b0;
    logic [9:0] bar_top = '0;
    logic [9:0] bar_bot = '0;
    logic [9:0] ball_x, ball_y;
    logic       ball_vis, hit, frame_upd;
    logic [1:0] state;
    logic [7:0] miss_cnt;

    always #5 clk = ~clk;

    ball_motion_ctrl #(
        .BALL_SIZE(BALL_SIZE), .STEP(STEP), .WALL_X(WALL_X), .BAR_X(BAR_X),
        .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .SERVE_X(SERVE_X),
        .SERVE_Y(SERVE_Y), .MISS_FRAMES(MISS_FRAMES)
    ) dut (
        .clk(clk), .reset(reset), .vsync(vsync), .serve(serve),
        .bar_top(bar_top), .bar_bot(bar_bot),
        .ball_x(ball_x), .ball_y(ball_y), .ball_vis(ball_vis), .state(state),
        .hit(hit), .frame_upd(frame_upd), .miss_cnt(miss_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Game model: state 0 idle, 1 run, 2 miss; directions are +1/-1.
    int m_st, m_x, m_y, m_dx, m_dy, m_vis, m_miss, m_hold, m_hit, m_upd;

    // Observations taken by run_frame: the cycle right after the tick edge,
    // and {hit, frame_upd} one cycle later.
    logic [9:0] o_x, o_y;
    logic       o_vis, o_hit, o_upd;
    logic [1:0] o_st;
    logic [7:0] o_miss;
    logic [1:0] o_p2;

    function automatic void model_reset();
        m_st = 0; m_x = SERVE_X; m_y = SERVE_Y; m_dx = 1; m_dy = 1;
        m_vis = 1; m_miss = 0; m_hold = 0; m_hit = 0; m_upd = 0;
    endfunction

    function automatic void model_tick(int bt, int bb, bit srv);
        int nx, ny, ndx, ndy;
        m_hit = 0;
        m_upd = 0;
        case (m_st)
            0: if (srv) m_st = 1;
            1: begin
                ny  = m_y + STEP * m_dy;
                ndy = m_dy;
                if (m_dy > 0 && ny >= SCREEN_H - BALL_SIZE) begin
                    ny = SCREEN_H - BALL_SIZE; ndy = -1;
                end
                if (ny < 0) begin
                    ny = 0; ndy = 1;
                end
                nx  = m_x + STEP * m_dx;
                ndx = m_dx;
                if (m_dx < 0 && nx <= WALL_X) begin
                    nx = WALL_X; ndx = 1;
                end else if (m_dx > 0 && nx + BALL_SIZE >= BAR_X && m_x + BALL_SIZE <= BAR_X &&
                             ny + BALL_SIZE > bt && ny < bb) begin
                    nx = BAR_X - BALL_SIZE; ndx = -1; m_hit = 1;
                end else if (m_dx > 0 && nx + BALL_SIZE >= SCREEN_W) begin
                    m_st = 2; m_vis = 0; m_hold = MISS_FRAMES;
                    if (m_miss < 255) m_miss++;
                    return;
                end
                m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy; m_upd = 1;
            end
            default: begin
                m_hold--;
                if (m_hold == 0) begin
                    m_st = 0; m_x = SERVE_X; m_y = SERVE_Y; m_dx = 1; m_dy = 1; m_vis = 1;
                end
            end
        endcase
    endfunction

    function automatic logic [34:0] exp_vec();
        return {10'(m_x), 10'(m_y), 1'(m_vis), 2'(m_st), 1'(m_hit), 1'(m_upd), 8'(m_miss), 2'b00};
    endfunction

    task automatic apply_reset();
        @(negedge clk); reset = 1'b1; vsync = 1'b1; serve = 1'b0;
        @(negedge clk); reset = 1'b0;
        model_reset();
    endtask

    task automatic pulse_serve();
        @(negedge clk); serve = 1'b1;
        @(negedge clk); serve = 1'b0;
        if (m_st == 0) m_st = 1;
    endtask

    // One short video frame; bar inputs carry junk except on the tick cycle.
    task automatic run_frame(input bit srv, input logic [9:0] bt, input logic [9:0] bb);
        @(negedge clk); vsync = 1'b0; bar_top = 10'($urandom); bar_bot = 10'($urandom);
        @(negedge clk);
        @(negedge clk); vsync = 1'b1; bar_top = bt; bar_bot = bb; serve = srv;
        @(negedge clk); serve = 1'b0; bar_top = 10'($urandom); bar_bot = 10'($urandom);
        o_x = ball_x; o_y = ball_y; o_vis = ball_vis; o_st = state;
        o_hit = hit; o_upd = frame_upd; o_miss = miss_cnt;
        model_tick(int'(bt), int'(bb), srv);
        @(negedge clk); o_p2 = {hit, frame_upd};
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if ({ball_x, ball_y, ball_vis, state, hit, frame_upd, miss_cnt} !==
            {10'd320, 10'd236, 1'b1, 2'b00, 1'b0, 1'b0, 8'd0}) begin
            bad++;
            $display("FAIL reset_vals got x=%0d y=%0d vis=%0d st=%0d hit=%0d upd=%0d miss=%0d want 320 236 1 0 0 0 0",
                     ball_x, ball_y, ball_vis, state, hit, frame_upd, miss_cnt);
        end
        for (int f = 1; f <= 3; f++) begin
            run_frame(1'b0, 10'($urandom), 10'($urandom));
            total++;
            if ({o_x, o_y, o_vis, o_st, o_upd, o_p2} !== {10'd320, 10'd236, 1'b1, 2'b00, 1'b0, 2'b00}) begin
                bad++;
                $display("FAIL idle_frame%0d got x=%0d y=%0d vis=%0d st=%0d upd=%0d p2=%0d want 320 236 1 0 0 0",
                         f, o_x, o_y, o_vis, o_st, o_upd, o_p2);
            end
        end
    endtask

    task automatic test_serve();
        apply_reset();
        pulse_serve();
        total++;
        if ({state, ball_x, ball_y, frame_upd} !== {2'b01, 10'd320, 10'd236, 1'b0}) begin
            bad++;
            $display("FAIL serve_state got st=%0d x=%0d y=%0d upd=%0d want 1 320 236 0", state, ball_x, ball_y, frame_upd);
        end
        run_frame(1'b0, 10'd0, 10'd0);
        total++;
        if ({o_x, o_y, o_upd, o_hit, o_p2} !== {10'd322, 10'd238, 1'b1, 1'b0, 2'b00}) begin
            bad++;
            $display("FAIL serve_first_move got x=%0d y=%0d upd=%0d hit=%0d p2=%0d want 322 238 1 0 0",
                     o_x, o_y, o_upd, o_hit, o_p2);
        end
    endtask

    task automatic test_serve_on_tick();
        apply_reset();
        run_frame(1'b1, 10'd0, 10'd0);
        total++;
        if ({o_st, o_x, o_y, o_upd} !== {2'b01, 10'd320, 10'd236, 1'b0}) begin
            bad++;
            $display("FAIL serve_tick got st=%0d x=%0d y=%0d upd=%0d want 1 320 236 0", o_st, o_x, o_y, o_upd);
        end
        run_frame(1'b0, 10'd0, 10'd0);
        total++;
        if ({o_x, o_y, o_upd} !== {10'd322, 10'd238, 1'b1}) begin
            bad++;
            $display("FAIL serve_tick_move got x=%0d y=%0d upd=%0d want 322 238 1", o_x, o_y, o_upd);
        end
    endtask

    // Full-height bar: bottom edge at frame 118, bar hit at 126, wall at 325, top at 355.
    task automatic test_bounces();
        logic [9:0] want_x, want_y;
        logic       want_hit;
        apply_reset();
        pulse_serve();
        for (int f = 1; f <= 356; f++) begin
            run_frame(1'b0, 10'd0, 10'd480);
            total++;
            if ({o_x, o_y, o_vis, o_st, o_hit, o_upd, o_miss, o_p2} !== exp_vec()) begin
                bad++;
                $display("FAIL bounce_model f=%0d got x=%0d y=%0d vis=%0d st=%0d hit=%0d upd=%0d miss=%0d p2=%0d want x=%0d y=%0d vis=%0d st=%0d hit=%0d upd=%0d miss=%0d",
                         f, o_x, o_y, o_vis, o_st, o_hit, o_upd, o_miss, o_p2,
                         m_x, m_y, m_vis, m_st, m_hit, m_upd, m_miss);
            end
            want_x = o_x; want_y = o_y; want_hit = 1'b0;
            case (f)
                118: want_y = 10'd472;
                119: want_y = 10'd470;
                126: begin want_x = 10'd572; want_hit = 1'b1; end
                127: want_x = 10'd570;
                325: want_x = 10'd175;
                326: want_x = 10'd177;
                355: want_y = 10'd0;
                356: want_y = 10'd2;
                default: want_hit = o_hit;
            endcase
            if (f inside {118, 119, 126, 127, 325, 326, 355, 356}) begin
                total++;
                if ({o_x, o_y, o_hit} !== {want_x, want_y, want_hit}) begin
                    bad++;
                    $display("FAIL bounce_edge f=%0d got x=%0d y=%0d hit=%0d want x=%0d y=%0d hit=%0d",
                             f, o_x, o_y, o_hit, want_x, want_y, want_hit);
                end
            end
        end
    endtask

    task automatic test_miss();
        apply_reset();
        pulse_serve();
        for (int f = 1; f <= 156; f++) begin
            run_frame(1'b0, 10'd0, 10'd10);
            total++;
            if ({o_x, o_y, o_vis, o_st, o_hit, o_upd, o_miss, o_p2} !== exp_vec() || o_hit !== 1'b0) begin
                bad++;
                $display("FAIL miss_run f=%0d got x=%0d y=%0d vis=%0d st=%0d hit=%0d upd=%0d miss=%0d p2=%0d want x=%0d y=%0d vis=%0d st=%0d hit=0 upd=%0d miss=%0d",
                         f, o_x, o_y, o_vis, o_st, o_hit, o_upd, o_miss, o_p2,
                         m_x, m_y, m_vis, m_st, m_upd, m_miss);
            end
        end
        total++;
        if ({o_st, o_vis, o_miss, o_upd} !== {2'b10, 1'b0, 8'd1, 1'b0}) begin
            bad++;
            $display("FAIL miss_enter got st=%0d vis=%0d miss=%0d upd=%0d want 2 0 1 0", o_st, o_vis, o_miss, o_upd);
        end
        pulse_serve();
        total++;
        if (state !== 2'b10) begin
            bad++;
            $display("FAIL miss_serve_ignored got st=%0d want 2", state);
        end
        for (int f = 1; f <= 60; f++) begin
            run_frame(f == 30, 10'($urandom), 10'($urandom));
            total++;
            if ({o_x, o_y, o_vis, o_st, o_hit, o_upd, o_miss, o_p2} !== exp_vec()) begin
                bad++;
                $display("FAIL miss_hold f=%0d got x=%0d y=%0d vis=%0d st=%0d miss=%0d want x=%0d y=%0d vis=%0d st=%0d miss=%0d",
                         f, o_x, o_y, o_vis, o_st, o_miss, m_x, m_y, m_vis, m_st, m_miss);
            end
            if (f >= 59) begin
                total++;
                if (f == 59 && o_st !== 2'b10) begin
                    bad++;
                    $display("FAIL miss_early_exit got st=%0d want 2", o_st);
                end else if (f == 60 && {o_st, o_x, o_y, o_vis} !== {2'b00, 10'd320, 10'd236, 1'b1}) begin
                    bad++;
                    $display("FAIL miss_exit got st=%0d x=%0d y=%0d vis=%0d want 0 320 236 1", o_st, o_x, o_y, o_vis);
                end
            end
        end
    endtask

    // Continues from test_miss (miss_cnt=1) so the clear of miss_cnt is visible.
    task automatic test_async_reset();
        pulse_serve();
        for (int f = 1; f <= 40; f++) run_frame(1'b0, 10'd0, 10'd10);
        total++;
        if ({o_st, o_x, o_y, o_miss} !== {2'b01, 10'd400, 10'd316, 8'd1}) begin
            bad++;
            $display("FAIL async_setup got st=%0d x=%0d y=%0d miss=%0d want 1 400 316 1", o_st, o_x, o_y, o_miss);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if ({ball_x, ball_y, ball_vis, state, hit, frame_upd, miss_cnt} !==
            {10'd320, 10'd236, 1'b1, 2'b00, 1'b0, 1'b0, 8'd0}) begin
            bad++;
            $display("FAIL async_reset got x=%0d y=%0d vis=%0d st=%0d hit=%0d upd=%0d miss=%0d want 320 236 1 0 0 0 0",
                     ball_x, ball_y, ball_vis, state, hit, frame_upd, miss_cnt);
        end
        @(negedge clk); reset = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        logic [9:0] bt, bb;
        bit         srv;
        for (int r = 0; r < 3; r++) begin
            apply_reset();
            for (int f = 1; f <= 250; f++) begin
                if ($urandom_range(0, 7) == 0) pulse_serve();
                srv = ($urandom_range(0, 7) == 0);
                bt  = 10'($urandom_range(0, 470));
                bb  = bt + 10'($urandom_range(0, 150));
                run_frame(srv, bt, bb);
                total++;
                if ({o_x, o_y, o_vis, o_st, o_hit, o_upd, o_miss, o_p2} !== exp_vec()) begin
                    bad++;
                    $display("FAIL random r=%0d f=%0d got x=%0d y=%0d vis=%0d st=%0d hit=%0d upd=%0d miss=%0d p2=%0d want x=%0d y=%0d vis=%0d st=%0d hit=%0d upd=%0d miss=%0d",
                             r, f, o_x, o_y, o_vis, o_st, o_hit, o_upd, o_miss, o_p2,
                             m_x, m_y, m_vis, m_st, m_hit, m_upd, m_miss);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_serve();
        test_serve_on_tick();
        test_bounces();
        test_miss();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
